shift_out_stage: RTL and testbench



---
 rtl/shift_out_stage.sv | 138 +++++++++++++
 tb/tb_shift_out_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/shift_out_stage.sv
// Narrows the widened shifter word to OUT_WIDTH with signed saturation and
// registers it through a 2-entry skid buffer. Optional counter: SHIFT_OUT_STATS_EN.
module shift_out_stage #(
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 stat_clr,
    output logic [CNT_WIDTH-1:0] sat_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [OUT_WIDTH-1:0]   main_data_q, main_data_d;
    logic [OUT_WIDTH-1:0]   skid_data_q, skid_data_d;
    logic                   main_sat_q, main_sat_d;
    logic                   skid_sat_q, skid_sat_d;
    logic [OUT_WIDTH-1:0]   narrow_data;
    logic                   narrow_sat;
    logic                   push;
    logic                   pop;

    // Bits that must all match the sign bit for the value to fit OUT_WIDTH.
    logic [IN_WIDTH-OUT_WIDTH:0] upper_bits;
    assign upper_bits = in_data[IN_WIDTH-1:OUT_WIDTH-1];

    always_comb begin
        narrow_sat  = !((&upper_bits) || !(|upper_bits));
        narrow_data = in_data[OUT_WIDTH-1:0];
        if (narrow_sat) begin
            narrow_data = in_data[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                              : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = main_data_q;
    assign out_sat   = main_sat_q;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sat_d  = main_sat_q;
        skid_data_d = skid_data_q;
        skid_sat_d  = skid_sat_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    main_data_d = narrow_data;
                    main_sat_d  = narrow_sat;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    main_data_d = narrow_data;
                    main_sat_d  = narrow_sat;
                end else if (push) begin
                    skid_data_d = narrow_data;
                    skid_sat_d  = narrow_sat;
                    state_d     = TWO;
                end else if (pop) begin
                    state_d     = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    main_data_d = skid_data_q;
                    main_sat_d  = skid_sat_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_sat_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sat_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sat_q  <= main_sat_d;
            skid_data_q <= skid_data_d;
            skid_sat_q  <= skid_sat_d;
        end
    end

`ifdef SHIFT_OUT_STATS_EN
    logic [CNT_WIDTH-1:0] sat_count_q, sat_count_d;

    // Clear has priority; the count sticks at all-ones instead of wrapping.
    always_comb begin
        sat_count_d = sat_count_q;
        if (stat_clr) begin
            sat_count_d = '0;
        end else if (push && narrow_sat && (sat_count_q != {CNT_WIDTH{1'b1}})) begin
            sat_count_d = sat_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;
`else
    logic stat_clr_unused;
    assign stat_clr_unused = stat_clr;
    assign sat_count       = '0;
`endif

endmodule

// File: tb/tb_shift_out_stage.sv
// Self-checking bench for shift_out_stage: directed vectors plus randomized
// traffic compared against a depth-2 FIFO reference model.
module tb_shift_out_stage;

    localparam int IN_W  = 24;
    localparam int OUT_W = 16;
    localparam int CNT_W = 8;
`ifdef SHIFT_OUT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic             out_valid;
    logic             out_ready;
    logic             stat_clr;
    logic [CNT_W-1:0] sat_count;

    int checks = 0;
    int errors = 0;

    // Reference model: ordered list of {sat, data} words held by the stage.
    logic [OUT_W:0] mq[$];
    int             model_cnt = 0;

    shift_out_stage #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .CNT_WIDTH(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stat_clr  (stat_clr),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W:0] narrow(input logic [IN_W-1:0] d);
        int v;
        v = int'($signed(d));
        if (v > 32767)  return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("sat_count", 32'(sat_count), STATS ? 32'(model_cnt) : 32'd0);
        if (mq.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(mq[0][OUT_W-1:0]));
            chk("out_sat", 32'(out_sat), 32'(mq[0][OUT_W]));
        end
    endtask

    // One clock: apply inputs, advance the model by the accepted transfers, compare.
    task automatic cycle(input logic v, input logic [IN_W-1:0] d,
                         input logic rdy, input logic clr);
        logic           push;
        logic           pop;
        logic [OUT_W:0] w;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        stat_clr  = clr;
        push = v && (mq.size() < 2);
        pop  = (mq.size() != 0) && rdy;
        w    = narrow(d);
        @(posedge clk);
        #1;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(w);
        if (clr) model_cnt = 0;
        else if (push && w[OUT_W] && model_cnt < 255) model_cnt++;
        check_model();
    endtask

    logic [IN_W-1:0]  vec_in [5] = '{24'h000123, 24'h012345, 24'hFF8000, 24'hFE0000, 24'hFF7FFF};
    logic [OUT_W-1:0] vec_out[5] = '{16'h0123, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000};
    logic             vec_sat[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [31:0]     r;
        logic [IN_W-1:0] d;
        int              drain;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stat_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        rst_n = 1'b1;

        // Narrowing vectors, one word per cycle with no backpressure.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, vec_in[i], 1'b1, 1'b0);
            chk("vec_data", 32'(out_data), 32'(vec_out[i]));
            chk("vec_sat", 32'(out_sat), 32'(vec_sat[i]));
            $display("vec %0d: in=%06h out=%04h sat=%0b", i, vec_in[i], out_data, out_sat);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("vec_drained", 32'(out_valid), 32'd0);

        // Backpressure fills the skid register, then drains in order.
        cycle(1'b1, 24'h000001, 1'b0, 1'b0);
        chk("bp_a_data", 32'(out_data), 32'h1);
        cycle(1'b1, 24'h000002, 1'b0, 1'b0);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_a", 32'(out_data), 32'h1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("bp_still_a", 32'(out_data), 32'h1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("bp_b_data", 32'(out_data), 32'h2);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("bp_empty", 32'(out_valid), 32'd0);
        $display("backpressure sequence done");

        // Random traffic: in_valid held high, random out_ready, mixed data.
        for (int i = 0; i < 1000; i++) begin
            r = $urandom;
            if (r[31:30] == 2'b00) d = r[23:0];
            else                   d = {{8{r[15]}}, r[15:0]};
            cycle(1'b1, d, ($urandom_range(0, 2) != 0), 1'b0);
        end
        drain = 0;
        while (mq.size() != 0 && drain < 10) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            drain++;
        end
        chk("rand_drained", 32'(mq.size()), 32'd0);
        chk("rand_out_valid", 32'(out_valid), 32'd0);
        $display("random phase done: %0d checks so far", checks);

        // Saturation counter: saturate, then clear against a saturating push.
        cycle(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) cycle(1'b1, 24'h7F0000, 1'b1, 1'b0);
        chk("cnt_saturated", 32'(sat_count), STATS ? 32'd255 : 32'd0);
        chk("cnt_out_sat", 32'(out_sat), 32'd1);
        cycle(1'b1, 24'h800000, 1'b1, 1'b1);
        chk("cnt_cleared", 32'(sat_count), 32'd0);
        cycle(1'b1, 24'h800000, 1'b1, 1'b0);
        chk("cnt_after_clr", 32'(sat_count), STATS ? 32'd1 : 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        $display("counter phase done: sat_count=%0d", sat_count);

        // Asynchronous reset while both registers hold words.
        cycle(1'b1, 24'h000011, 1'b0, 1'b0);
        cycle(1'b1, 24'hFE0000, 1'b0, 1'b0);
        chk("two_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_sat_count", 32'(sat_count), 32'd0);
        mq.delete();
        model_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 24'h000005, 1'b1, 1'b0);
        chk("post_rst_data", 32'(out_data), 32'h5);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        $display("reset phase done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
